systolic_skew_feeder: RTL and testbench

Upstream operand stage for the 8x8 `Systolic_Array`. It buffers one A matrix and one B matrix, loaded a row per write. On `start` it streams them into the array's left (`a1..a57`) and top (`b1..b8`) edges with the diagonal skew that output-stationary accumulation needs. After the feed it holds zeros for a programmable drain period, then pulses `done` to mark that the array's `c` outputs are final.

---
 rtl/systolic_skew_feeder.sv | 170 +++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one A and one B operand matrix and streams them
// into an NxN output-stationary systolic array with diagonal skew, then holds
// zeros for a drain period and pulses done once the array results are final.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_SIZE   = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic                             wr_sel,
    input  logic [$clog2(ARRAY_SIZE)-1:0]    wr_row,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_out,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_out
);

    localparam int N  = ARRAY_SIZE;
    localparam int DW = DATA_WIDTH;
    // Feed counter spans t = 0 .. 2N-2
    localparam int TW = $clog2(2 * N - 1);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [TW-1:0] LAST_T     = TW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [TW-1:0]       t_q;
    logic [CW-1:0]       drain_q;
    logic                busy_q;
    logic                done_q;
    logic [N*DW-1:0]     a_out_q;
    logic [N*DW-1:0]     b_out_q;

    logic [DW-1:0]       a_buf_q [N][N];
    logic [DW-1:0]       b_buf_q [N][N];
    logic [DW-1:0]       a_buf_d [N][N];
    logic [DW-1:0]       b_buf_d [N][N];

    logic                wr_ok;
    logic [TW-1:0]       t_sel;
    logic [N*DW-1:0]     a_skew;
    logic [N*DW-1:0]     b_skew;

    // Writes land only while no feed is in flight
    assign wr_ok = wr_en && (state_q == S_IDLE || state_q == S_DONE);

    // Next buffer contents; the feed reads these so a write paired with start is seen at t=0
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (wr_ok) begin
            for (int k = 0; k < N; k++) begin
                if (!wr_sel) a_buf_d[wr_row][k] = wr_data[k*DW +: DW];
                else         b_buf_d[wr_row][k] = wr_data[k*DW +: DW];
            end
        end
    end

    // Skewed operand vectors for the feed step about to be registered
    always_comb begin
        t_sel  = (state_q == S_FEED) ? t_q + TW'(1) : '0;
        a_skew = '0;
        b_skew = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                // Element k of row/column i is due when t == i + k
                if (int'(t_sel) == i + k) begin
                    a_skew[i*DW +: DW] = a_buf_d[i][k];
                    b_skew[i*DW +: DW] = b_buf_d[k][i];
                end
            end
        end
    end

    // Operand buffer storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the buffers are reset on purpose: a run started right after reset must stream zeros.
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_buf_q[i][k] <= '0;
                    b_buf_q[i][k] <= '0;
                end
            end
        end else begin
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
        end
    end

    // Run sequencing with registered busy/done and skewed operand outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignment so every register sees pre-edge values.
            done_q  <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FEED;
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        a_out_q <= a_skew;
                        b_out_q <= b_skew;
                    end
                end
                S_FEED: begin
                    if (t_q == LAST_T) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end
                    end else begin
                        t_q     <= t_q + TW'(1);
                        a_out_q <= a_skew;
                        b_out_q <= b_skew;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign a_out = a_out_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: scoreboard bench for the skew feeder, with a small
// behavioural output-stationary array hanging off its edges.
module tb_systolic_skew_feeder;

    localparam int N        = 8;
    localparam int DW       = 8;
    localparam int D        = 8;
    localparam int LAST_T   = 2 * N - 2;
    localparam int DONE_LAT = 2 * N - 1 + D;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_en = 1'b0;
    logic            wr_sel = 1'b0;
    logic [2:0]      wr_row = '0;
    logic [N*DW-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;

    systolic_skew_feeder #(
        .DATA_WIDTH  (DW),
        .ARRAY_SIZE  (N),
        .DRAIN_CYCLES(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_row (wr_row),
        .wr_data(wr_data),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .a_out  (a_out),
        .b_out  (b_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int              ref_a [N][N];
    int              ref_b [N][N];
    logic [N*DW-1:0] qa [$];
    logic [N*DW-1:0] qb [$];
    logic [N*DW-1:0] obs_a [2*N];
    logic [N*DW-1:0] obs_b [2*N];

    int done_cnt = 0;
    always @(negedge clk) if (done) done_cnt++;

    // Behavioural array: a moves right, b moves down, each PE accumulates a*b
    logic [DW-1:0] pe_a [N][N];
    logic [DW-1:0] pe_b [N][N];
    int            acc  [N][N];

    function automatic logic [DW-1:0] a_in(int i, int j);
        return (j == 0) ? a_out[i*DW +: DW] : pe_a[i][(j == 0) ? 0 : j - 1];
    endfunction

    function automatic logic [DW-1:0] b_in(int i, int j);
        return (i == 0) ? b_out[j*DW +: DW] : pe_b[(i == 0) ? 0 : i - 1][j];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                    acc[i][j]  <= 0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j]  <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
                    pe_a[i][j] <= a_in(i, j);
                    pe_b[i][j] <= b_in(i, j);
                end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] row_vec(bit sel, int r);
        logic [N*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++)
            v[k*DW +: DW] = sel ? DW'(ref_b[r][k]) : DW'(ref_a[r][k]);
        return v;
    endfunction

    task automatic load_all();
        for (int r = 0; r < N; r++)
            for (int s = 0; s < 2; s++) begin
                wr_en   = 1'b1;
                wr_sel  = s[0];
                wr_row  = 3'(r);
                wr_data = row_vec(s[0], r);
                step();
                wr_en = 1'b0;
            end
    endtask

    task automatic push_expected();
        logic [N*DW-1:0] ea, eb;
        for (int t = 0; t <= LAST_T; t++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) ea[i*DW +: DW] = DW'(ref_a[i][t-i]);
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < N) eb[j*DW +: DW] = DW'(ref_b[t-j][j]);
            qa.push_back(ea);
            qb.push_back(eb);
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        step();
        #3 rst = 1'b0;
        step();
    endtask

    // One full run from IDLE; optional stray start/write at t=5 and write paired with start
    task automatic run_feed(input string tag, input bit poke_t5, input bit wr_with_start);
        int cyc;
        int d0;
        logic [N*DW-1:0] ea, eb;
        if (wr_with_start) begin
            for (int k = 0; k < N; k++) ref_a[0][k] = 'h55;
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_row  = 3'd0;
            wr_data = row_vec(1'b0, 0);
        end
        start = 1'b1;
        push_expected();
        d0 = done_cnt;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        for (int t = 0; t <= LAST_T; t++) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            obs_a[t] = a_out;
            obs_b[t] = b_out;
            check({tag, "_a"}, a_out, ea);
            check({tag, "_b"}, b_out, eb);
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (poke_t5 && t == 5) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 3'd3;
                wr_data = '1;
            end
            step();
            start = 1'b0;
            wr_en = 1'b0;
        end
        obs_a[2*N-1] = a_out;
        obs_b[2*N-1] = b_out;
        check({tag, "_drain_a"}, a_out, 64'd0);
        check({tag, "_drain_b"}, b_out, 64'd0);
        check({tag, "_drain_busy"}, 64'(busy), 64'd1);
        cyc = 2 * N - 1;
        while (!done && cyc < DONE_LAT + 20) begin
            step();
            cyc++;
        end
        check({tag, "_done_lat"}, 64'(cyc), 64'(DONE_LAT));
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        step();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        repeat (3) step();
        check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_c(input string tag, input int scale);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check(tag, 64'(acc[i][j]), 64'(scale * (i + j)));
    endtask

    task automatic set_pattern();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ref_a[i][k] = 16 * i + k + 1;
                ref_b[i][k] = 16 * i + k + 1;
            end
    endtask

    initial begin
        int d0;
        // Reset asserted between clock edges takes effect immediately
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_a", a_out, 64'd0);
        check("rst_b", b_out, 64'd0);
        step();
        #3 rst = 1'b0;
        step();

        // Skew pattern
        set_pattern();
        load_all();
        run_feed("skew", 1'b0, 1'b0);
        check("skew_t0_a", obs_a[0], 64'h0000_0000_0000_0001);
        check("skew_t0_b", obs_b[0], 64'h0000_0000_0000_0001);
        check("skew_t7_a0", 64'(obs_a[7][0 +: DW]), 64'h08);
        check("skew_t7_a7", 64'(obs_a[7][7*DW +: DW]), 64'h71);
        check("skew_t7_b7", 64'(obs_b[7][7*DW +: DW]), 64'h08);
        check("skew_t14_a", obs_a[14], 64'h7800_0000_0000_0000);
        check("skew_t14_b", obs_b[14], 64'h7800_0000_0000_0000);
        check("skew_t15_a", obs_a[15], 64'd0);
        check("skew_t15_b", obs_b[15], 64'd0);

        // Ignored start and write mid-feed; following run must show row 3 intact
        run_feed("ign", 1'b1, 1'b0);
        run_feed("ign2", 1'b0, 1'b0);

        // End to end through the behavioural array
        pulse_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ref_a[i][k] = (i == k) ? 1 : 0;
                ref_b[i][k] = i + k;
            end
        load_all();
        run_feed("e2e1", 1'b0, 1'b0);
        check_c("c_run1", 1);
        pulse_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) ref_a[i][k] = (i == k) ? 2 : 0;
        load_all();
        run_feed("e2e2", 1'b0, 1'b0);
        check_c("c_run2", 2);

        // Reset in the middle of FEED
        set_pattern();
        load_all();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("abort_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_a", a_out, 64'd0);
        check("abort_b", b_out, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        #3 rst = 1'b0;
        step();
        d0 = done_cnt;
        repeat (30) step();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ref_a[i][k] = 0;
                ref_b[i][k] = 0;
            end
        run_feed("fresh", 1'b0, 1'b0);

        // Write of A row 0 in the same cycle as start
        run_feed("wrstart", 1'b0, 1'b1);
        for (int t = 0; t < N; t++)
            check("wrstart_slice0", 64'(obs_a[t][0 +: DW]), 64'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
